// File: rtl/multicycle_ctrl_if.sv
// Shared memory-port handshake between the control FSM and memory.
// The master issues requests; the slave answers with a done strobe.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    output mem_ack
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// RV32I multicycle main control FSM over one shared memory port.
// Optional ILLEGAL_TRAP_EN: unknown opcodes trap instead of acting as NOP.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_instr,
  input  logic        i_br_taken,
  multicycle_ctrl_if.master m_mem,
  output logic        o_ir_we,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_sel,
  output logic        o_alu_a_sel,
  output logic        o_alu_b_sel,
  output logic        o_alu_fn_en,
  output logic        o_addr_sel,
  output logic        o_rf_we,
  output logic [1:0]  o_wb_sel,
  output logic        o_err,
  output logic        o_illegal,
  output logic [2:0]  o_state
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_ERR    = 3'd6,
    S_TRAP   = 3'd7
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  logic [6:0] w_op;
  logic w_is_op, w_is_opi, w_is_ld, w_is_st;
  logic w_is_br, w_is_jal, w_is_jalr, w_is_lui;
  logic w_is_auipc, w_is_nop, w_known;
  logic w_unused;

  assign w_op       = i_instr[6:0];
  assign w_is_op    = (w_op == 7'b0110011);
  assign w_is_opi   = (w_op == 7'b0010011);
  assign w_is_ld    = (w_op == 7'b0000011);
  assign w_is_st    = (w_op == 7'b0100011);
  assign w_is_br    = (w_op == 7'b1100011);
  assign w_is_jal   = (w_op == 7'b1101111);
  assign w_is_jalr  = (w_op == 7'b1100111);
  assign w_is_lui   = (w_op == 7'b0110111);
  assign w_is_auipc = (w_op == 7'b0010111);
  assign w_is_nop   = (w_op == 7'b0001111)
                    | (w_op == 7'b1110011);
  assign w_known    = w_is_op | w_is_opi | w_is_ld
                    | w_is_st | w_is_br | w_is_jal
                    | w_is_jalr | w_is_lui
                    | w_is_auipc | w_is_nop;
  assign w_unused   = &{1'b0, i_instr[31:7]};

  logic       w_ir_we, w_pc_we, w_a_sel, w_b_sel;
  logic       w_fn_en, w_req, w_we, w_addr_sel;
  logic       w_rf_we, w_wait;
  logic [1:0] w_pc_sel, w_wb_sel;

  always_comb begin
    w_nxt      = r_state;
    w_ir_we    = 1'b0;
    w_pc_we    = 1'b0;
    w_pc_sel   = 2'd0;
    w_a_sel    = 1'b0;
    w_b_sel    = 1'b0;
    w_fn_en    = 1'b0;
    w_req      = 1'b0;
    w_we       = 1'b0;
    w_addr_sel = 1'b0;
    w_rf_we    = 1'b0;
    w_wb_sel   = 2'd0;
    w_wait     = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (m_mem.mem_ack) begin
          w_ir_we = 1'b1;
          w_nxt   = S_DECODE;
        end else if (r_cnt == LAST) begin
          w_nxt = S_ERR;
        end else begin
          w_wait = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_is_nop) begin
          w_pc_we = 1'b1;
          w_nxt   = S_FETCH;
        end else if (!w_known) begin
`ifdef ILLEGAL_TRAP_EN
          w_nxt = S_TRAP;
`else
          w_pc_we = 1'b1;
          w_nxt   = S_FETCH;
`endif
        end else begin
          w_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_nxt = S_FETCH;
        unique case (1'b1)
          w_is_op, w_is_opi: begin
            w_fn_en = 1'b1;
            w_b_sel = w_is_opi;
            w_nxt   = S_WB;
          end
          w_is_ld, w_is_st: begin
            w_b_sel = 1'b1;
            w_nxt   = S_MEM;
          end
          w_is_br: begin
            w_pc_we  = 1'b1;
            w_pc_sel = i_br_taken ? 2'd1 : 2'd0;
          end
          w_is_jal: begin
            w_rf_we  = 1'b1;
            w_wb_sel = 2'd2;
            w_pc_we  = 1'b1;
            w_pc_sel = 2'd1;
          end
          w_is_jalr: begin
            w_b_sel  = 1'b1;
            w_rf_we  = 1'b1;
            w_wb_sel = 2'd2;
            w_pc_we  = 1'b1;
            w_pc_sel = 2'd2;
          end
          w_is_lui: begin
            w_rf_we  = 1'b1;
            w_wb_sel = 2'd3;
            w_pc_we  = 1'b1;
          end
          w_is_auipc: begin
            w_a_sel = 1'b1;
            w_b_sel = 1'b1;
            w_nxt   = S_WB;
          end
          default: w_nxt = S_FETCH;
        endcase
      end
      S_MEM: begin
        w_req      = 1'b1;
        w_addr_sel = 1'b1;
        w_we       = w_is_st;
        w_b_sel    = 1'b1;
        if (m_mem.mem_ack) begin
          w_pc_we = w_is_st;
          w_nxt   = w_is_st ? S_FETCH : S_WB;
        end else if (r_cnt == LAST) begin
          w_nxt = S_ERR;
        end else begin
          w_wait = 1'b1;
        end
      end
      S_WB: begin
        // ALU selects held so the WB mux sees the EXEC result
        w_fn_en  = w_is_op | w_is_opi;
        w_b_sel  = w_is_opi | w_is_ld | w_is_auipc;
        w_a_sel  = w_is_auipc;
        w_rf_we  = 1'b1;
        w_wb_sel = w_is_ld ? 2'd1 : 2'd0;
        w_pc_we  = 1'b1;
        w_nxt    = S_FETCH;
      end
      S_ERR, S_TRAP: w_nxt = r_state;
      default: w_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_wait ? r_cnt + 1'b1 : '0;
      r_err   <= r_err | (w_nxt == S_ERR);
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic r_ill;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ill <= 1'b0;
    else        r_ill <= r_ill | (w_nxt == S_TRAP);
  end
  assign o_illegal = r_ill;
`else
  assign o_illegal = 1'b0;
`endif

  // Strobes are forced low while reset is held
  assign o_ir_we        = rst_n & w_ir_we;
  assign o_pc_we        = rst_n & w_pc_we;
  assign o_pc_sel       = {2{rst_n}} & w_pc_sel;
  assign o_alu_a_sel    = rst_n & w_a_sel;
  assign o_alu_b_sel    = rst_n & w_b_sel;
  assign o_alu_fn_en    = rst_n & w_fn_en;
  assign o_addr_sel     = rst_n & w_addr_sel;
  assign o_rf_we        = rst_n & w_rf_we;
  assign o_wb_sel       = {2{rst_n}} & w_wb_sel;
  assign m_mem.mem_req  = rst_n & w_req;
  assign m_mem.mem_we   = rst_n & w_we;
  assign o_err          = r_err;
  assign o_state        = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed cases plus random instruction
// streams checked against a per-instruction expected cycle trace.
module tb_multicycle_ctrl;

  localparam int TO = 16;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_FEN = 7'b0001111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = '0;
  logic        br = 1'b0;
  logic        ir_we, pc_we, a_sel, b_sel, fn_en;
  logic        addr_sel, rf_we, err, ill;
  logic [1:0]  pc_sel, wb_sel;
  logic [2:0]  state;

  multicycle_ctrl_if mif();

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_instr     (instr),
    .i_br_taken  (br),
    .m_mem       (mif.master),
    .o_ir_we     (ir_we),
    .o_pc_we     (pc_we),
    .o_pc_sel    (pc_sel),
    .o_alu_a_sel (a_sel),
    .o_alu_b_sel (b_sel),
    .o_alu_fn_en (fn_en),
    .o_addr_sel  (addr_sel),
    .o_rf_we     (rf_we),
    .o_wb_sel    (wb_sel),
    .o_err       (err),
    .o_illegal   (ill),
    .o_state     (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       ir, pw;
    logic [1:0] ps;
    logic       a, b, fn, req, we, as, rf;
    logic [1:0] wb;
    logic       er, il;
  } ob_t;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic ob_t sample();
    ob_t s;
    s.st = state;  s.ir = ir_we;  s.pw = pc_we;
    s.ps = pc_sel; s.a = a_sel;   s.b = b_sel;
    s.fn = fn_en;  s.req = mif.mem_req;
    s.we = mif.mem_we; s.as = addr_sel;
    s.rf = rf_we;  s.wb = wb_sel;
    s.er = err;    s.il = ill;
    return s;
  endfunction

  function automatic bit known(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR,
                      OP_JAL, OP_JR, OP_LUI, OP_AUI,
                      OP_FEN, OP_SYS};
  endfunction

  // Async reset asserted mid-cycle; ends at posedge+1 in FETCH
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    mif.mem_ack = 1'b1;
    #1 check("reset", 32'(sample()), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mif.mem_ack = 1'b0;
  endtask

  // Builds the expected cycle trace from the instruction's class,
  // then drives ack per cycle and compares. Returns 1 if it trapped.
  task automatic run_instr(input string nm,
                           input logic [31:0] ins,
                           input logic bt,
                           input int fd, input int md,
                           output bit trapped);
    ob_t  q[$];
    logic ak[$];
    ob_t  e;
    logic [6:0] op;
    logic ea, eb, efn;
    int   npw, nrf, xpw, xrf;
    op = ins[6:0];
    trapped = 1'b0;
    instr = ins;
    br = bt;
    for (int i = 0; i < fd; i++) begin
      e = '0; e.req = 1'b1;
      q.push_back(e); ak.push_back(1'b0);
    end
    e = '0; e.req = 1'b1; e.ir = 1'b1;
    q.push_back(e); ak.push_back(1'b1);
    e = '0; e.st = 3'd1;
    if (op == OP_FEN || op == OP_SYS || (!known(op) && !TRAP)) begin
      e.pw = 1'b1;
      q.push_back(e); ak.push_back(1'($urandom));
    end else if (!known(op)) begin
      q.push_back(e); ak.push_back(1'($urandom));
      trapped = 1'b1;
      for (int i = 0; i < 3; i++) begin
        e = '0; e.st = 3'd7; e.il = 1'b1;
        q.push_back(e); ak.push_back(1'($urandom));
      end
    end else begin
      q.push_back(e); ak.push_back(1'($urandom));
      e = '0; e.st = 3'd2;
      case (op)
        OP_R:   e.fn = 1'b1;
        OP_I:   begin e.fn = 1'b1; e.b = 1'b1; end
        OP_LD, OP_ST: e.b = 1'b1;
        OP_BR:  begin e.pw = 1'b1; e.ps = bt ? 2'd1 : 2'd0; end
        OP_JAL: begin e.rf = 1'b1; e.wb = 2'd2;
                      e.pw = 1'b1; e.ps = 2'd1; end
        OP_JR:  begin e.b = 1'b1; e.rf = 1'b1; e.wb = 2'd2;
                      e.pw = 1'b1; e.ps = 2'd2; end
        OP_LUI: begin e.rf = 1'b1; e.wb = 2'd3; e.pw = 1'b1; end
        OP_AUI: begin e.a = 1'b1; e.b = 1'b1; end
        default: ;
      endcase
      ea = e.a; eb = e.b; efn = e.fn;
      q.push_back(e); ak.push_back(1'($urandom));
      if (op == OP_LD || op == OP_ST) begin
        for (int i = 0; i <= md; i++) begin
          e = '0; e.st = 3'd3; e.req = 1'b1; e.as = 1'b1;
          e.b = 1'b1; e.we = (op == OP_ST);
          e.pw = (i == md) && (op == OP_ST);
          q.push_back(e); ak.push_back(i == md);
        end
      end
      if (op inside {OP_R, OP_I, OP_LD, OP_AUI}) begin
        e = '0; e.st = 3'd4; e.rf = 1'b1; e.pw = 1'b1;
        e.wb = (op == OP_LD) ? 2'd1 : 2'd0;
        e.a = ea; e.b = eb; e.fn = efn;
        q.push_back(e); ak.push_back(1'($urandom));
      end
    end
    npw = 0; nrf = 0;
    foreach (q[k]) begin
      mif.mem_ack = ak[k];
      #1;
      check($sformatf("%s c%0d", nm, k), 32'(sample()), 32'(q[k]));
      npw += int'(pc_we);
      nrf += int'(rf_we);
      @(posedge clk);
      #1;
    end
    xpw = trapped ? 0 : 1;
    xrf = (!trapped && op inside {OP_R, OP_I, OP_LD, OP_JAL,
                                  OP_JR, OP_LUI, OP_AUI}) ? 1 : 0;
    check({nm, " pc_we#"}, 32'(npw), 32'(xpw));
    check({nm, " rf_we#"}, 32'(nrf), 32'(xrf));
    if (!trapped) check({nm, " next"}, 32'(state), 32'd0);
  endtask

  initial begin
    bit tr;
    logic [6:0] op;
    logic [6:0] ops[11];
    mif.mem_ack = 1'b0;
    ops = '{OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL,
            OP_JR, OP_LUI, OP_AUI, OP_FEN, OP_SYS};
    #3;
    check("in reset", 32'(sample()), 32'd0);
    do_reset();

    run_instr("addi", 32'h00500093, 1'b0, 0, 0, tr);
    run_instr("lw", 32'h0000A103, 1'b0, 3, 2, tr);
    run_instr("beq t", 32'h00000463, 1'b1, 0, 0, tr);
    run_instr("beq n", 32'h00000463, 1'b0, 0, 0, tr);
    run_instr("jalr", 32'h000080E7, 1'b0, 1, 0, tr);
    run_instr("ill7f", 32'h0000007F, 1'b0, 0, 0, tr);
    if (tr) do_reset();

    // Fetch timeout: 16 unacked cycles end in ERR
    do_reset();
    mif.mem_ack = 1'b0;
    for (int i = 0; i < TO; i++) begin
      #1 check($sformatf("to wait%0d", i), 32'(state), 32'd0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      mif.mem_ack = 1'($urandom);
      #1;
      check("to err", 32'(sample()),
            32'(ob_t'{st: 3'd6, er: 1'b1, default: '0}));
      @(posedge clk); #1;
    end

    // Ack in the final allowed cycle still wins
    do_reset();
    for (int i = 0; i < TO; i++) begin
      mif.mem_ack = (i == TO - 1);
      @(posedge clk); #1;
    end
    check("late ack st", 32'(state), 32'd1);
    check("late ack err", 32'(err), 32'd0);

    // Reset while a load waits in MEM aborts with no write
    do_reset();
    instr = 32'h0000A103;
    mif.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      mif.mem_ack = 1'b0;
    end
    check("abort pre", 32'(state), 32'd3);
    do_reset();
    run_instr("post abort", 32'h00500093, 1'b0, 0, 0, tr);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        do op = 7'($urandom); while (known(op));
      end else begin
        op = ops[$urandom_range(0, 10)];
      end
      run_instr($sformatf("rnd%0d", n),
                {25'($urandom), op}, 1'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 4), tr);
      if (tr) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
